booth_seq_mult: RTL and testbench
=================================

Name: booth_seq_mult

Overview:
- Parametrised, iterative Booth multiplier. Successor to the 4-bit combinational Booth array.
- One recode/add/arithmetic-shift-right step per clock, WIDTH-generic, with signed and unsigned operand modes per transaction.
- Valid/ready handshake on both input and output, so it slots into datapaths as a multi-cycle arithmetic unit beside the array multipliers.

Parameters:
- WIDTH, 8, operand width in bits; must be even, 4..32.
- ITER (localparam, not overridable), WIDTH+1 in radix-2 build, WIDTH/2+1 in radix-4 build; number of step cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- is_signed  in  1  1: operands are two's complement; 0: unsigned
- mcand  in  WIDTH  multiplicand (M)
- mplier  in  WIDTH  multiplier (Q)
- out_valid  out  1  product available
- out_ready  in  1  consumer takes product
- product  out  2*WIDTH  M*Q, signed or unsigned per captured is_signed
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset: one clock and a synchronous, active-low reset. On a clk edge with rst_n=0, state is IDLE, in_ready=1, out_valid=0, busy=0, product=0, iteration counter=0. Reset wins over every other event, including mid-RUN and mid-DONE. Any in-flight result is discarded.
- Internal operands are extended to N=WIDTH+1 bits (radix-4: WIDTH+2):
  - sign-extended when is_signed=1;
  - zero-extended when is_signed=0.
  - This makes unsigned full-range inputs correct.
- State register Z = {acc[N-1:0], q[N-1:0], q_m1}.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture extended M, load acc=0, q=extended Q, q_m1=0, cnt=0, and go to RUN.
  - RUN: each cycle, recode {q[0],q_m1}:
    - 01: acc+=M
    - 10: acc-=M
    - 00/11: no-op
    - Then arithmetic-shift {acc,q,q_m1} right by 1 with acc MSB replicated, and cnt++.
    - When cnt reaches ITER-1 the step completes, state goes to DONE, and product = lower 2*WIDTH bits of {acc,q} after the final shift.
  - DONE: out_valid=1. Product is held stable while out_ready=0, for any number of cycles. On out_valid&&out_ready, go to IDLE and drop out_valid. in_ready stays 0 during DONE; no same-cycle accept.
- Latency: out_valid rises exactly ITER cycles after the accepting edge. Throughput is one result per ITER+2 cycles minimum.
- Arithmetic: acc add/sub is done in N bits with wrap. Extension guarantees no overflow loss in the product.
- Inputs are sampled only at the accept edge. Changes on mcand, mplier and is_signed during RUN/DONE have no effect.
- in_valid while busy is ignored; no queueing.

Optional Feature:
- Macro: BOOTH_SEQ_MULT_RADIX4_EN.
- Defined:
  - Modified Booth recoding of {q[1],q[0],q_m1} each cycle, with digits 0, ±M, ±2M.
  - Shift is 2 bits arithmetic per cycle.
  - N=WIDTH+2, ITER=WIDTH/2+1.
  - Handshake, ports and results are identical.
- Undefined: radix-2 as above, ITER=WIDTH+1.

Decomposition:
- Package booth_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - Booth digit encoding constants (NOP, ADD1, SUB1, ADD2, SUB2);
  - function iter_count(WIDTH, radix4).
- Sub-module booth_recoder: combinational; bit pair/triple in, digit out. Shared by both radix builds.
- The FSM, datapath and counter stay in booth_seq_mult.

Test Plan:
- Signed multiply (WIDTH=8, radix-2): is_signed=1, mcand=8'hFD (-3), mplier=8'h05 → product=16'hFFF1 (-15); out_valid exactly 9 cycles after accept.
- Unsigned full range: is_signed=0, mcand=mplier=8'hFF → product=16'hFE01 (65025).
- Signed extremes: is_signed=1, 8'h80*8'h80 → 16'h4000; 8'h80*8'h7F → 16'hC080.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid, toggling mcand/mplier/in_valid → product stable, in_ready=0, no second accept; the out_ready pulse returns to IDLE the next cycle.
- Reset mid-op: rst_n=0 at RUN cycle 4 → next edge IDLE, out_valid=0, product=0. A fresh 7*6 then yields 16'h002A.
- Randomised sweep: 1000 random operand pairs in both modes, in both the radix-2 build and the BOOTH_SEQ_MULT_RADIX4_EN build → product matches the reference model. Radix-4 latency is 5 cycles for WIDTH=8.

Source files
------------

// File: rtl/booth_pkg.sv
// ============================================================================
// Module   : booth_pkg
// Brief    : Shared states, Booth digit codes and iteration count for booth_seq_mult.
// Revision : 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ADD1 = 3'd1,
        SUB1 = 3'd2,
        ADD2 = 3'd3,
        SUB2 = 3'd4
    } digit_t;

    // Step count: one per retired multiplier bit (radix-2) or bit pair (radix-4).
    function automatic int iter_count(input int width, input bit radix4);
        return radix4 ? (width / 2 + 1) : (width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_recoder.sv
// ============================================================================
// Module   : booth_recoder
// Brief    : Modified Booth recoder, {q[i+1], q[i], q[i-1]} -> digit in {0, +-M, +-2M}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0] triple,
    output digit_t     digit
);

    // Radix-2 callers feed {q0, q0, q_m1}; that only ever reaches 000/001/110/111,
    // which collapse onto the plain Booth pair table.
    always_comb begin
        digit = NOP;
        case (triple)
            3'b001, 3'b010: digit = ADD1;
            3'b011:         digit = ADD2;
            3'b100:         digit = SUB2;
            3'b101, 3'b110: digit = SUB1;
            default:        digit = NOP;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/booth_seq_mult.sv
// ============================================================================
// Module   : booth_seq_mult
// Brief    : Iterative Booth multiplier with valid/ready handshake, signed/unsigned per op.
//            Define BOOTH_SEQ_MULT_RADIX4_EN for the radix-4 (two bits per cycle) build.
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

`ifdef BOOTH_SEQ_MULT_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    // Extra headroom bits let unsigned full-range operands and the 2M digit fit without loss.
    localparam int N     = RADIX4 ? WIDTH + 2 : WIDTH + 1;
    localparam int SHIFT = RADIX4 ? 2 : 1;
    localparam int ITER  = iter_count(WIDTH, RADIX4);
    localparam int CNT_W = $clog2(ITER);

    generate
        if ((WIDTH % 2 != 0) || (WIDTH < 4) || (WIDTH > 32)) begin : g_width_check
            $error("booth_seq_mult: WIDTH must be even and within 4..32");
        end
    endgenerate

    state_t             state;
    state_t             state_next;
    logic [N-1:0]       mcand_x;
    logic [N-1:0]       acc;
    logic [N-1:0]       q;
    logic               q_m1;
    logic [CNT_W-1:0]   cnt;

    logic [2:0]         rec_triple;
    digit_t             digit;
    logic [N-1:0]       addend;
    logic [N-1:0]       sum;
    logic signed [2*N:0] z_next;
    logic               accept;
    logic               last_step;
    logic               ext_m;
    logic               ext_q;

    generate
        if (RADIX4) begin : g_radix4
            assign rec_triple = {q[1], q[0], q_m1};
        end else begin : g_radix2
            assign rec_triple = {q[0], q[0], q_m1};
        end
    endgenerate

    booth_recoder u_recoder (
        .triple (rec_triple),
        .digit  (digit)
    );

    always_comb begin
        addend = '0;
        case (digit)
            ADD1:    addend = mcand_x;
            SUB1:    addend = '0 - mcand_x;
            ADD2:    addend = mcand_x << 1;
            SUB2:    addend = '0 - (mcand_x << 1);
            default: addend = '0;
        endcase
    end

    assign sum       = acc + addend;
    assign z_next    = $signed({sum, q, q_m1}) >>> SHIFT;
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CNT_W'(ITER - 1));
    assign ext_m     = is_signed & mcand[WIDTH-1];
    assign ext_q     = is_signed & mplier[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_x <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand_x <= {{(N-WIDTH){ext_m}}, mcand};
            acc     <= '0;
            q       <= {{(N-WIDTH){ext_q}}, mplier};
            q_m1    <= 1'b0;
            cnt     <= '0;
        end else if (state == RUN) begin
            acc  <= z_next[2*N:N+1];
            q    <= z_next[N:1];
            q_m1 <= z_next[0];
            cnt  <= cnt + 1'b1;
            if (last_step) begin
                product <= z_next[2*WIDTH:1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
// ============================================================================
// Module   : tb_booth_seq_mult
// Brief    : Scoreboard bench for booth_seq_mult (WIDTH=8, either radix build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_booth_seq_mult;

    localparam int W = 8;
`ifdef BOOTH_SEQ_MULT_RADIX4_EN
    localparam int LAT = W / 2 + 1;
`else
    localparam int LAT = W + 1;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             is_signed = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     mcand     = '0;
    logic [W-1:0]     mplier    = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [2*W-1:0]   product;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [2*W-1:0]   sb[$];

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .mcand     (mcand),
        .mplier    (mplier),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mult(input logic sgn, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] p;
        ea = sgn ? {{(64-W){a[W-1]}}, a} : {{(64-W){1'b0}}, a};
        eb = sgn ? {{(64-W){b[W-1]}}, b} : {{(64-W){1'b0}}, b};
        p  = ea * eb;
        return p[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair and return #1 after the accepting edge.
    task automatic start(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check_val("ready_before_accept", in_ready, 1);
        is_signed = sgn;
        mcand     = a;
        mplier    = b;
        in_valid  = 1'b1;
        sb.push_back(exp);
        tick();
        in_valid = 1'b0;
        check_val("busy_after_accept", {busy, in_ready}, 2'b10);
    endtask

    task automatic wait_result(output logic [2*W-1:0] exp);
        int t;
        t = 0;
        while (!out_valid && t < 200) begin
            tick();
            t++;
        end
        check_val("out_valid_timeout", out_valid, 1);
        check_val("latency", t, LAT);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check_val("product", product, exp);
    endtask

    task automatic release_result(input int hold);
        for (int i = 0; i < hold; i++) tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("idle_after_release", {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        logic [2*W-1:0] exp;
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;

        rst_n = 1'b0;
        repeat (3) tick();
        check_val("reset_state", {in_ready, out_valid, busy}, 3'b100);
        check_val("reset_product", product, 0);
        rst_n = 1'b1;
        tick();

        // Directed operands and signed/unsigned corners
        start(1'b1, 8'hFD, 8'h05, 16'hFFF1); wait_result(exp); release_result(0);
        start(1'b0, 8'hFF, 8'hFF, 16'hFE01); wait_result(exp); release_result(1);
        start(1'b1, 8'h80, 8'h80, 16'h4000); wait_result(exp); release_result(0);
        start(1'b1, 8'h80, 8'h7F, 16'hC080); wait_result(exp); release_result(0);
        start(1'b1, 8'hFF, 8'hFF, 16'h0001); wait_result(exp); release_result(0);
        start(1'b0, 8'h80, 8'hFF, 16'h7F80); wait_result(exp); release_result(0);

        // Backpressure with operand churn while the result is held
        start(1'b0, 8'h0C, 8'h0B, 16'h0084);
        wait_result(exp);
        for (int i = 0; i < 20; i++) begin
            mcand    = W'($urandom);
            mplier   = W'($urandom);
            in_valid = ~in_valid;
            tick();
            check_val("bp_product", product, 16'h0084);
            check_val("bp_flags", {out_valid, in_ready, busy}, 3'b101);
        end
        release_result(0);

        // Reset in the middle of a run
        start(1'b1, 8'h37, 8'h5A, ref_mult(1'b1, 8'h37, 8'h5A));
        void'(sb.pop_back());
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check_val("midrun_reset_flags", {in_ready, out_valid, busy}, 3'b100);
        check_val("midrun_reset_product", product, 0);
        rst_n = 1'b1;
        tick();
        start(1'b0, 8'h07, 8'h06, 16'h002A); wait_result(exp); release_result(0);

        // Random sweep; operands are scrambled while busy to prove they are not resampled
        for (int i = 0; i < 1000; i++) begin
            sgn = 1'($urandom);
            a   = W'($urandom);
            b   = W'($urandom);
            start(sgn, a, b, ref_mult(sgn, a, b));
            mcand     = W'($urandom);
            mplier    = W'($urandom);
            is_signed = 1'($urandom);
            in_valid  = 1'($urandom);
            wait_result(exp);
            release_result(int'($urandom_range(0, 2)));
        end

        check_val("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
